// File: rtl/text_blitter.sv
// text_blitter: renders a COLS x ROWS character buffer through an 8x8 font
// and streams 24-bit pixels in raster order into a framebuffer write port.
module text_blitter #(
  parameter int          COLS = 40,
  parameter int          ROWS = 25,
  parameter logic [23:0] FG   = 24'hFFFFFF,
  parameter logic [23:0] BG   = 24'h000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [9:0]  txt_adr,
  input  logic [7:0]  txt_d,
  output logic [9:0]  font_adr,
  input  logic [7:0]  font_d,
  output logic [15:0] fb_wadr,
  output logic        fb_we,
  output logic [23:0] fb_d
);

  typedef enum logic [2:0] {IDLE, T_REQ, T_DATA, F_REQ, F_DATA, PIX} state_t;

  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [7:0] Y_LAST    = 8'(ROWS * 8 - 1);
  localparam logic [9:0] ROW_PITCH = 10'(COLS);

  state_t     state, state_d;
  logic [6:0] col, col_n;
  logic [7:0] y, y_n;
  logic [9:0] row_base, base_n;
  logic [2:0] pix_cnt;
  logic [7:0] chr;
  logic [7:0] shifter;
  logic       last_pix, last_col, last_grp;

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic and next-group position
  always_comb begin
    state_d  = state;
    last_pix = (pix_cnt == 3'd7);
    last_col = (col == COL_LAST);
    last_grp = last_col && (y == Y_LAST);
    col_n    = last_col ? '0 : col + 7'd1;
    y_n      = last_col ? y + 8'd1 : y;
    base_n   = (last_col && (y[2:0] == 3'd7)) ? row_base + ROW_PITCH : row_base;
    case (state)
      IDLE:    if (start) state_d = T_REQ;
      T_REQ:   state_d = T_DATA;
      T_DATA:  state_d = F_REQ;
      F_REQ:   state_d = F_DATA;
      F_DATA:  state_d = PIX;
      PIX:     if (last_pix) state_d = last_grp ? IDLE : T_REQ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: counters, fetch registers and registered outputs.
  // Each output is loaded one edge ahead so it is valid in the cycle its state occupies.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      txt_adr  <= '0;
      font_adr <= '0;
      fb_wadr  <= '0;
      fb_we    <= 1'b0;
      fb_d     <= '0;
      col      <= '0;
      y        <= '0;
      row_base <= '0;
      pix_cnt  <= '0;
      chr      <= '0;
      shifter  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            col      <= '0;
            y        <= '0;
            row_base <= '0;
            txt_adr  <= '0;
            fb_wadr  <= '0;
          end
        end
        T_DATA: begin
          chr      <= txt_d;
          font_adr <= {txt_d[6:0], y[2:0]};
        end
        F_DATA: begin
          shifter <= {font_d[6:0], 1'b0};
          fb_we   <= 1'b1;
          fb_d    <= (font_d[7] ^ chr[7]) ? FG : BG;
          pix_cnt <= '0;
        end
        PIX: begin
          fb_wadr <= fb_wadr + 16'd1;
          pix_cnt <= pix_cnt + 3'd1;
          if (!last_pix) begin
            fb_d    <= (shifter[7] ^ chr[7]) ? FG : BG;
            shifter <= {shifter[6:0], 1'b0};
          end else begin
            fb_we <= 1'b0;
            if (last_grp) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              col      <= col_n;
              y        <= y_n;
              row_base <= base_n;
              txt_adr  <= base_n + {3'b000, col_n};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_blitter.sv
// tb_text_blitter: random text/font contents checked against a per-frame
// list of expected (address, colour) writes plus cycle-exact timing checks.
module tb_text_blitter;

  localparam int          COLS  = 5;
  localparam int          ROWS  = 3;
  localparam logic [23:0] FG    = 24'hF0A055;
  localparam logic [23:0] BG    = 24'h0A0B0C;
  localparam int          FRAME = ROWS * 8 * COLS * 12;
  localparam int          NPIX  = ROWS * COLS * 64;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, fb_we;
  logic [9:0]  txt_adr, font_adr;
  logic [7:0]  txt_d, font_d;
  logic [15:0] fb_wadr;
  logic [23:0] fb_d;

  logic [7:0]  txt_mem  [1024];
  logic [7:0]  font_mem [1024];

  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [39:0] exp_q[$];
  bit          active = 1'b0;
  int          ns = 0, writes = 0, frames_done = 0;

  text_blitter #(.COLS(COLS), .ROWS(ROWS), .FG(FG), .BG(BG)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .txt_adr(txt_adr), .txt_d(txt_d), .font_adr(font_adr), .font_d(font_d),
    .fb_wadr(fb_wadr), .fb_we(fb_we), .fb_d(fb_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    txt_d  <= txt_mem[txt_adr];
    font_d <= font_mem[font_adr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Whole-frame reference: every pixel in raster order from the glyph rules.
  task automatic build_frame();
    logic [7:0] ch, g;
    logic [9:0] fa;
    bit         lit;
    exp_q.delete();
    for (int yy = 0; yy < ROWS * 8; yy++)
      for (int c = 0; c < COLS; c++) begin
        ch = txt_mem[(yy / 8) * COLS + c];
        fa = {ch[6:0], 3'(yy % 8)};
        g  = font_mem[fa];
        for (int b = 0; b < 8; b++) begin
          lit = g[7 - b] ^ ch[7];
          exp_q.push_back({16'(yy * COLS * 8 + c * 8 + b), lit ? FG : BG});
        end
      end
  endtask

  // Monitor: timing, fetch addresses and pixel stream against the reference.
  always @(negedge clk) begin
    int rel, phase, grp, gy, gc;
    logic [7:0]  ch;
    logic [9:0]  fe;
    logic [39:0] e;
    if (reset) begin
      check_val("rst_we", fb_we, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      active = 1'b0;
      exp_q.delete();
    end else begin
      if (active) begin
        rel = cyc - ns;
        if (done) begin
          check_val("done_cycle", rel, FRAME + 1);
          check_val("write_count", writes, NPIX);
          check_val("busy_at_done", busy, 0);
          active = 1'b0;
          frames_done++;
        end else begin
          check_val("busy", busy, 1);
          phase = (rel - 1) % 12;
          grp   = (rel - 1) / 12;
          gy    = grp / COLS;
          gc    = grp % COLS;
          if (phase == 0) check_val("txt_adr", txt_adr, (gy / 8) * COLS + gc);
          if (phase == 2) begin
            ch = txt_mem[(gy / 8) * COLS + gc];
            fe = {ch[6:0], 3'(gy % 8)};
            check_val("font_adr", font_adr, fe);
          end
          if (fb_we) begin
            check_val("we_phase", phase >= 4, 1);
            if (writes == 0) check_val("first_we_cycle", rel, 5);
            if (exp_q.size() == 0) check_val("extra_write", 1, 0);
            else begin
              e = exp_q.pop_front();
              check_val("fb_wadr", fb_wadr, e[39:24]);
              check_val("fb_d", fb_d, e[23:0]);
            end
            writes++;
          end
        end
      end else begin
        if (fb_we) check_val("stray_we", 1, 0);
        if (done)  check_val("stray_done", 1, 0);
      end
      if (start && !busy) begin
        build_frame();
        ns     = cyc;
        writes = 0;
        active = 1'b1;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < FRAME + 50; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    check_val("done_timeout", 0, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) begin
      txt_mem[i]  = 8'($urandom);
      font_mem[i] = 8'($urandom);
    end
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      txt_mem[i]  = '0;
      font_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_we", fb_we, 0);
    check_val("reset_wadr", fb_wadr, 0);
    check_val("reset_fb_d", fb_d, 0);
    check_val("reset_txt_adr", txt_adr, 0);
    check_val("reset_font_adr", font_adr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Blank text and font: every pixel BG
    pulse_start();
    wait_done();
    repeat (3) @(posedge clk);

    // Normal and inverse 'A' with a single glyph line set
    txt_mem[0] = 8'h41;
    txt_mem[1] = 8'hC1;
    font_mem[10'h208] = 8'h18;
    pulse_start();
    wait_done();
    repeat (3) @(posedge clk);

    // Random frame, ignored start mid-frame, then start in the done cycle
    fill_random();
    pulse_start();
    repeat (100) @(posedge clk);
    pulse_start();
    wait_done();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);

    // Reset mid-frame, then a clean frame from address 0
    fill_random();
    pulse_start();
    repeat (500) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_val("midrst_we", fb_we, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_wadr", fb_wadr, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    pulse_start();
    wait_done();
    repeat (3) @(posedge clk);

    check_val("frames_done", frames_done, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_blitter.md
# text_blitter

Upstream stage of the VGA `framebuffer`. On a start pulse it renders a 40×25 character text buffer through an 8×8 font into 320×200 24-bit pixels. It streams the pixels into the framebuffer's write port (`fb_wadr`/`fb_we`/`fb_d`) in raster order. The text RAM and the font ROM sit outside the block and are read through synchronous ports.

## Interface
- `COLS`, 40, characters per text row
- `ROWS`, 25, text rows; requires `COLS*8*ROWS*8 <= 65536`
- `FG`, 24'hFFFFFF, colour for set glyph bits
- `BG`, 24'h000000, colour for clear glyph bits
- `CLOCK_50`  in  1  sole clock; framebuffer write port, text RAM and font ROM are all clocked by it
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request to render one full frame
- `busy`  out  1  high while a frame is being rendered
- `done`  out  1  one-cycle pulse when the frame completes
- `txt_adr`  out  10  text RAM address, `row*COLS + col`
- `txt_d`  in  8  text RAM data, valid the cycle after `txt_adr`
- `font_adr`  out  10  font ROM address `{char[6:0], line[2:0]}`
- `font_d`  in  8  glyph line, valid the cycle after `font_adr`; MSB is the leftmost pixel
- `fb_wadr`  out  16  framebuffer write address, `y*COLS*8 + x`
- `fb_we`  out  1  framebuffer write strobe
- `fb_d`  out  24  pixel colour {R,G,B}

## Operation
- States:
  - IDLE
  - T_REQ: `txt_adr` presented
  - T_DATA: `txt_d` latched into the char register
  - F_REQ: `font_adr` presented from the char register and line `y[2:0]`
  - F_DATA: `font_d` latched into the 8-bit shifter
  - PIX: 8 cycles, one pixel per cycle
- IDLE→T_REQ when `start`=1. `start` is ignored in every other state.
- One group is 8 pixels, i.e. one character on one scan line. After PIX completes the group, the FSM goes back to T_REQ for the next group, or to IDLE after the last group (y=199, col=COLS−1).
- Order is raster: for y in 0..ROWS*8−1, for col in 0..COLS−1.
- Text row base:
  - advances by COLS when `y[2:0]` wraps 7→0;
  - each text row is therefore fetched 8 times, once per scan line.
- Inverse video:
  - char bit 7 = 1 inverts the pixel selection (bit 1→BG, bit 0→FG);
  - `font_adr` always uses `char[6:0]`.
- `fb_wadr`:
  - starts at 0 for each frame;
  - increments by 1 after every write;
  - final write is at 63999;
  - no gaps, no repeats.
- Pixel colour in PIX: `fb_d` = (shifter MSB XOR inverse) ? FG : BG. The shifter shifts left once per pixel.
- `fb_we` is high only during PIX cycles.

## Timing
- All outputs are registered.
- Reset values:
  - `busy`=0, `done`=0, `fb_we`=0;
  - `fb_wadr`=0, `fb_d`=0;
  - `txt_adr`=0, `font_adr`=0;
  - FSM in IDLE, row/col/line counters at 0.
- Group cadence is 12 cycles: T_REQ, T_DATA, F_REQ, F_DATA, PIX×8.
- Frame length is 200×40×12 = 96000 cycles of `busy`=1.
- Edge N samples `start`=1. Then:
  - `busy`=1 from cycle N+1 (T_REQ);
  - first `fb_we`=1 in cycle N+5 with `fb_wadr`=0;
  - last write in cycle N+96000.
- Completion: `done`=1 for exactly cycle N+96001, the same cycle `busy` returns to 0. A `start` sampled in that cycle starts a new frame.
- `start` while `busy`: no effect, no queueing.
- Asynchronous `reset` mid-frame:
  - immediately forces IDLE and all outputs to their reset values;
  - `fb_we` drops in the same cycle;
  - no `done` pulse;
  - the next `start` renders from `fb_wadr`=0.
- `txt_d`/`font_d` are sampled only in T_DATA/F_DATA; values at any other time are ignored.

## Test plan
- Reset asserted ~500 cycles into a frame → `fb_we`, `busy` and `done` are 0 while `reset` is high. A subsequent `start` gives a first write at `fb_wadr`=0 in cycle N+5.
- Text RAM all 0x00, font line 0x00 everywhere → exactly 64000 writes, addresses 0..63999 contiguous, all `fb_d`=BG. `done` pulses once at N+96001.
- txt[0]=0x41, font[{0x41,0}]=0x18 → `font_adr`=0x208 in the first F_REQ. Writes 0..7 = BG,BG,BG,FG,FG,BG,BG,BG.
- txt[1]=0xC1, same font → `font_adr`=0x208. Writes 8..15 = FG,FG,FG,BG,BG,FG,FG,FG.
- Row boundary → `txt_adr` sequence 0..39 repeated 8 times (y=0..7), then 40 at y=8. `font_adr[2:0]` cycles 0..7 with y.
- Pulse `start` at cycle N+100 of a frame → no restart; total writes still 64000. A `start` in the `done` cycle begins a new frame, with `busy` staying 1 and `fb_wadr` restarting at 0.
